// File: rtl/reg_checkpoint_store.sv
// rtl/reg_checkpoint_store.sv - multi-slot register-file/PC checkpoint store with beat-wise transfers
module reg_checkpoint_store #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_SLOTS      = 4,
    parameter int WORDS_PER_BEAT = 4,
    parameter int ZERO_X0        = 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           WRITE,
    input  logic                           READ,
    input  logic [$clog2(NUM_SLOTS)-1:0]   SLOT,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] IN_DATA,
    input  logic [DATA_WIDTH-1:0]          PC_IN,
    output logic [NUM_REGS*DATA_WIDTH-1:0] OUT_DATA,
    output logic [DATA_WIDTH-1:0]          PC_OUT,
    output logic                           BUSYWAIT,
    output logic                           DONE,
    output logic                           ERROR,
    output logic [NUM_SLOTS-1:0]           SLOT_VALID
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int BEATS  = NUM_REGS / WORDS_PER_BEAT;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE} state_t;
    state_t state, state_next;

    logic [BEAT_W-1:0]              beat;
    logic [SLOT_W-1:0]              cur_slot;
    logic [NUM_REGS*DATA_WIDTH-1:0] stage_data;
    logic [DATA_WIDTH-1:0]          stage_pc;
    logic [DATA_WIDTH-1:0]          slot_mem [NUM_SLOTS][NUM_REGS];
    logic [DATA_WIDTH-1:0]          slot_pc  [NUM_SLOTS];
    logic                           last_beat;
    logic                           req_ok;
    logic                           accept_write;
    logic                           accept_read;
    logic                           reject_read;

    assign last_beat    = (beat == BEAT_W'(BEATS - 1));
    assign req_ok       = (state == ST_IDLE) && !BUSYWAIT;
    assign accept_write = req_ok && WRITE;
    assign accept_read  = req_ok && !WRITE && READ && SLOT_VALID[SLOT];
    assign reject_read  = req_ok && !WRITE && READ && !SLOT_VALID[SLOT];

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_write)
                    state_next = ST_SAVE;
                else if (accept_read)
                    state_next = ST_RESTORE;
            end
            ST_SAVE, ST_RESTORE: begin
                if (last_beat)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Staging and slot storage carry no reset; validity is tracked in SLOT_VALID.
    always_ff @(posedge CLK) begin
        if (accept_write) begin
            stage_data <= IN_DATA;
            stage_pc   <= PC_IN;
        end
        if (state == ST_SAVE) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (BEAT_W'(r / WORDS_PER_BEAT) == beat)
                    slot_mem[cur_slot][r] <= (ZERO_X0 != 0 && r == 0) ? '0
                                             : stage_data[r*DATA_WIDTH +: DATA_WIDTH];
            end
            if (last_beat)
                slot_pc[cur_slot] <= stage_pc;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            beat       <= '0;
            cur_slot   <= '0;
            OUT_DATA   <= '0;
            PC_OUT     <= '0;
            BUSYWAIT   <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            SLOT_VALID <= '0;
        end else begin
            state <= state_next;
            DONE  <= 1'b0;
            ERROR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_write || accept_read) begin
                        cur_slot <= SLOT;
                        BUSYWAIT <= 1'b1;
                        beat     <= '0;
                    end else if (reject_read) begin
                        ERROR <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    beat <= beat + 1'b1;
                    if (last_beat) begin
                        SLOT_VALID[cur_slot] <= 1'b1;
                        BUSYWAIT             <= 1'b0;
                        DONE                 <= 1'b1;
                    end
                end
                ST_RESTORE: begin
                    for (int r = 0; r < NUM_REGS; r++) begin
                        if (BEAT_W'(r / WORDS_PER_BEAT) == beat)
                            OUT_DATA[r*DATA_WIDTH +: DATA_WIDTH] <= slot_mem[cur_slot][r];
                    end
                    beat <= beat + 1'b1;
                    if (last_beat) begin
                        PC_OUT   <= slot_pc[cur_slot];
                        BUSYWAIT <= 1'b0;
                        DONE     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_checkpoint_store.sv
// tb/tb_reg_checkpoint_store.sv - self-checking bench for reg_checkpoint_store
module tb_reg_checkpoint_store;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NS = 4;
    localparam int K_SAVE = 0;
    localparam int K_REST = 1;
    localparam int K_ERR  = 2;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           WRITE;
    logic           READ;
    logic [1:0]     SLOT;
    logic [NR*DW-1:0] IN_DATA;
    logic [DW-1:0]  PC_IN;
    logic [NR*DW-1:0] OUT_DATA;
    logic [DW-1:0]  PC_OUT;
    logic           BUSYWAIT;
    logic           DONE;
    logic           ERROR;
    logic [NS-1:0]  SLOT_VALID;

    reg_checkpoint_store dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .READ(READ), .SLOT(SLOT),
        .IN_DATA(IN_DATA), .PC_IN(PC_IN), .OUT_DATA(OUT_DATA), .PC_OUT(PC_OUT),
        .BUSYWAIT(BUSYWAIT), .DONE(DONE), .ERROR(ERROR), .SLOT_VALID(SLOT_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int              kind;
        logic [1:0]      slot;
        logic [NR*DW-1:0] out;
        logic [DW-1:0]   pc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  slot;
        logic [31:0] base;
        logic [31:0] pc;
        logic        scramble;
        logic        exp_err;
        logic [3:0]  exp_valid;
    } vec_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              mon_idx;
    vec_t            vecs[12];
    int              n_checks = 0;
    int              n_fail = 0;
    logic [DW-1:0]   model_mem [NS][NR];
    logic [DW-1:0]   model_pc [NS];
    logic [NS-1:0]   model_valid;
    logic [NR*DW-1:0] model_out;
    logic [DW-1:0]   model_pc_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] base, input logic [31:0] pc);
        for (int i = 0; i < NR; i++)
            IN_DATA[i*DW +: DW] = base + 32'(i);
        PC_IN = pc;
    endtask

    task automatic push_req(input logic wr, input logic rd, input logic [1:0] slot,
                            input logic [31:0] base, input logic [31:0] pc);
        exp_t e;
        e.kind = K_ERR;
        e.slot = slot;
        e.out  = model_out;
        e.pc   = model_pc_out;
        if (wr) begin
            e.kind = K_SAVE;
            for (int i = 0; i < NR; i++)
                model_mem[slot][i] = (i == 0) ? 32'd0 : base + 32'(i);
            model_pc[slot]    = pc;
            model_valid[slot] = 1'b1;
        end else if (rd && model_valid[slot]) begin
            e.kind = K_REST;
            for (int i = 0; i < NR; i++)
                model_out[i*DW +: DW] = model_mem[slot][i];
            model_pc_out = model_pc[slot];
            e.out = model_out;
            e.pc  = model_pc_out;
        end
        sb.push_back(e);
    endtask

    task automatic run_op(input logic wr, input logic rd, input logic [1:0] slot,
                          input logic [31:0] base, input logic [31:0] pc,
                          input logic scramble, input logic exp_err);
        int   busy;
        logic got_done;
        logic got_err;
        busy = 0;
        got_done = 1'b0;
        got_err = 1'b0;
        set_in(base, pc);
        SLOT  = slot;
        WRITE = wr;
        READ  = rd;
        push_req(wr, rd, slot, base, pc);
        @(posedge CLK);
        @(negedge CLK);
        WRITE = 1'b0;
        READ  = 1'b0;
        if (scramble)
            set_in(~base, ~pc);
        for (int i = 0; i < 20; i++) begin
            if (DONE || ERROR) begin
                got_done = DONE;
                got_err  = ERROR;
                break;
            end
            if (BUSYWAIT)
                busy++;
            @(negedge CLK);
        end
        chk("resp_seen", 64'(got_done | got_err), 64'd1);
        chk("error_pulse", 64'(got_err), 64'(exp_err));
        chk("busy_cycles", 64'(busy), exp_err ? 64'd0 : 64'd8);
        @(negedge CLK);
        chk("pulse_width", 64'({DONE, ERROR}), 64'd0);
    endtask

    // Scoreboard: each DONE/ERROR pulse retires the oldest expected transfer.
    always @(negedge CLK) begin
        if (!RESET && (DONE || ERROR)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got done=%0b error=%0b expected no response", DONE, ERROR);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_kind", 64'({DONE, ERROR}), (mon_e.kind == K_ERR) ? 64'd1 : 64'd2);
                mon_idx = -1;
                for (int i = 0; i < NR; i++)
                    if (mon_idx < 0 && OUT_DATA[i*DW +: DW] !== mon_e.out[i*DW +: DW])
                        mon_idx = i;
                if (mon_idx < 0)
                    mon_idx = 0;
                chk($sformatf("out_reg%0d", mon_idx), 64'(OUT_DATA[mon_idx*DW +: DW]),
                    64'(mon_e.out[mon_idx*DW +: DW]));
                chk("pc_out", 64'(PC_OUT), 64'(mon_e.pc));
                if (mon_e.kind == K_SAVE)
                    chk($sformatf("slot_valid_bit%0d", mon_e.slot), 64'(SLOT_VALID[mon_e.slot]), 64'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int dones;
        vecs[0]  = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0,   1'b0, 1'b1, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h1000,      32'h80,  1'b0, 1'b0, 4'b0010};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0,   1'b0, 1'b0, 4'b0010};
        vecs[3]  = '{1'b1, 1'b1, 2'd0, 32'hAAAA_0000, 32'h100, 1'b0, 1'b0, 4'b0011};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 32'h200, 1'b1, 1'b0, 4'b0011};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'h0001_0000, 32'h201, 1'b1, 1'b0, 4'b0011};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'h0002_0000, 32'h202, 1'b1, 1'b0, 4'b0111};
        vecs[7]  = '{1'b1, 1'b0, 2'd3, 32'h0003_0000, 32'h203, 1'b1, 1'b0, 4'b1111};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h0,   1'b0, 1'b0, 4'b1111};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0,   1'b0, 1'b0, 4'b1111};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0,   1'b0, 1'b0, 4'b1111};
        vecs[11] = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0,   1'b0, 1'b0, 4'b1111};

        model_valid  = '0;
        model_out    = '0;
        model_pc_out = '0;
        RESET = 1'b1;
        WRITE = 1'b0;
        READ  = 1'b0;
        SLOT  = 2'd0;
        set_in(32'h0, 32'h0);
        repeat (2) @(negedge CLK);
        chk("rst_busywait", 64'(BUSYWAIT), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_error", 64'(ERROR), 64'd0);
        chk("rst_slot_valid", 64'(SLOT_VALID), 64'd0);
        chk("rst_out_nonzero", 64'(|OUT_DATA), 64'd0);
        chk("rst_pc_out", 64'(PC_OUT), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Reset mid-SAVE aborts the transfer and wipes every valid bit.
        run_op(1'b1, 1'b0, 2'd0, 32'h5500_0000, 32'h44, 1'b0, 1'b0);
        chk("pre_abort_valid", 64'(SLOT_VALID), 64'b0001);
        set_in(32'h2222_0000, 32'h90);
        SLOT  = 2'd2;
        WRITE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        WRITE = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("abort_busywait", 64'(BUSYWAIT), 64'd0);
        chk("abort_slot_valid", 64'(SLOT_VALID), 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        model_valid  = '0;
        model_out    = '0;
        model_pc_out = '0;
        @(negedge CLK);
        RESET = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE)
                dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        run_op(1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            run_op(vecs[k].wr, vecs[k].rd, vecs[k].slot, vecs[k].base, vecs[k].pc,
                   vecs[k].scramble, vecs[k].exp_err);
            chk($sformatf("slot_valid_v%0d", k), 64'(SLOT_VALID), 64'(vecs[k].exp_valid));
        end

        // WRITE held high: one acceptance every 9 edges, READ pulses ignored.
        for (int c = 0; c < 27; c++) begin
            if (c % 9 == 0) begin
                SLOT = 2'(c / 9);
                set_in(32'hC000_0000 | 32'(c << 8), 32'h400 + 32'(c));
                WRITE = 1'b1;
                push_req(1'b1, 1'b0, SLOT, 32'hC000_0000 | 32'(c << 8), 32'h400 + 32'(c));
            end
            READ = (c % 9 == 4);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("hold_busy_c%0d", c), 64'(BUSYWAIT), 64'((c % 9) != 8));
        end
        WRITE = 1'b0;
        READ  = 1'b0;
        run_op(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("final_slot_valid", 64'(SLOT_VALID), 64'b1111);
        repeat (3) @(negedge CLK);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
